sw_popcount_matcher: RTL and testbench

//  Parametrised switch-group popcount detector for board switch/LED designs. Splits sw into N_CH

---
 rtl/sw_popcount_pkg.sv | 35 +++
 rtl/sw_popcount_matcher_debounce.sv | 52 +++++
 rtl/sw_popcount_matcher.sv | 73 +++++++
 tb/tb_sw_popcount_matcher.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sw_popcount_pkg.sv
// rtl/sw_popcount_pkg.sv - mode encodings and popcount/compare helpers for sw_popcount_matcher
package sw_popcount_pkg;

    localparam int POP_MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_EQ  = 2'b00,
        MODE_GE  = 2'b01,
        MODE_LE  = 2'b10,
        MODE_ODD = 2'b11
    } mode_e;

    function automatic logic [5:0] popcount(input logic [POP_MAX_W-1:0] vec);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {5'd0, vec[i]};
        end
        return c;
    endfunction

    // Operands are zero-extended by the caller so the compare is unsigned at any CNT_W.
    function automatic logic compare(input logic [7:0] pop, input logic [7:0] target,
                                     input logic [1:0] mode);
        logic r;
        case (mode)
            MODE_EQ:  r = (pop == target);
            MODE_GE:  r = (pop >= target);
            MODE_LE:  r = (pop <= target);
            default:  r = pop[0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sw_popcount_matcher_debounce.sv
// rtl/sw_popcount_matcher_debounce.sv - sw_debounce: 2-flop synchroniser plus stable-count debounce for one channel
module sw_debounce #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] sw_i,
    output logic [W-1:0] stable_o
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYCLES - 1);

    logic [W-1:0]  sync1_q, sync2_q;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  stable_q, stable_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    always_comb begin
        cand_d   = cand_q;
        dcnt_d   = dcnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            stable_d = cand_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            dcnt_q   <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            dcnt_q   <= dcnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/sw_popcount_matcher.sv
// rtl/sw_popcount_matcher.sv - per-channel debounced switch popcount compare driving LEDs; MATCH_COUNT_EN adds match counters
module sw_popcount_matcher
    import sw_popcount_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int CH_W       = 4,
    parameter int DEB_CYCLES = 4,
    localparam int CNT_W     = $clog2(CH_W + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*CH_W-1:0]  sw,
    input  logic [N_CH*CNT_W-1:0] target,
    input  logic [N_CH*2-1:0]     mode,
`ifdef MATCH_COUNT_EN
    output logic [N_CH*8-1:0]     match_cnt,
`endif
    output logic [N_CH-1:0]       led
);

    logic [N_CH-1:0] led_q, led_d;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CH_W-1:0]  stable;
        logic [CNT_W-1:0] pop;

        sw_debounce #(
            .W          (CH_W),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk_i    (clk),
            .rst_i    (reset),
            .sw_i     (sw[c*CH_W +: CH_W]),
            .stable_o (stable)
        );

        assign pop      = CNT_W'(popcount(POP_MAX_W'(stable)));
        assign led_d[c] = compare(8'(pop), 8'(target[c*CNT_W +: CNT_W]), mode[c*2 +: 2]);

`ifdef MATCH_COUNT_EN
        logic [7:0] cnt_q, cnt_d;

        // A rising led_d against the current led_q is exactly a 0->1 transition on the next edge.
        always_comb begin
            cnt_d = cnt_q;
            if (led_d[c] && !led_q[c] && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign match_cnt[c*8 +: 8] = cnt_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_sw_popcount_matcher.sv
// tb/tb_sw_popcount_matcher.sv - directed self-checking bench for sw_popcount_matcher
module tb_sw_popcount_matcher;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic [5:0] target;
    logic [3:0] mode;
    logic [1:0] led;
`ifdef MATCH_COUNT_EN
    logic [15:0] match_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sw_popcount_matcher #(
        .N_CH       (2),
        .CH_W       (4),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .target    (target),
        .mode      (mode),
`ifdef MATCH_COUNT_EN
        .match_cnt (match_cnt),
`endif
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        sw     = 8'h00;
        mode   = 4'b00_10;
        target = {3'd0, 3'd2};

        // Reset held while switches wiggle
        step(1);
        chk("rst_led_a", 16'(led), 16'h0);
        sw = 8'hA5;
        step(2);
        chk("rst_led_b", 16'(led), 16'h0);
        sw = 8'h5A;
        step(3);
        chk("rst_led_c", 16'(led), 16'h0);
`ifdef MATCH_COUNT_EN
        chk("rst_cnt", match_cnt, 16'h0);
`endif
        sw = 8'h00;
        step(1);
        reset = 1'b0;

        // First edge after reset: ch0 LE 2 with pop 0, ch1 EQ 0 with pop 0
        step(1);
        chk("first_edge", 16'(led), 16'h3);

        mode   = 4'b00_00;
        target = {3'd1, 3'd2};
        step(1);
        chk("eq_after_mode", 16'(led), 16'h0);

        // Basic EQ match and latency of 8 edges
        sw = 8'b0001_0011;
        step(7);
        chk("t2_edge7", 16'(led), 16'h0);
        step(1);
        chk("t2_edge8", 16'(led), 16'h3);

        sw = 8'b0011_0111;
        step(7);
        chk("t2b_edge7", 16'(led), 16'h3);
        step(1);
        chk("t2b_edge8", 16'(led), 16'h0);

        // Short glitch on sw[2] is rejected
        sw = 8'b0001_0011;
        step(8);
        chk("t3_match", 16'(led), 16'h3);
        sw = 8'b0001_0111;
        step(3);
        sw = 8'b0001_0011;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("t3_glitch_hold", 16'(led), 16'h3);
        end
        sw = 8'b0001_0111;
        step(7);
        chk("t3_held_edge7", 16'(led), 16'h3);
        step(1);
        chk("t3_held_edge8", 16'(led), 16'h2);

        // Mode sweep on ch0 with pop=3
        mode[1:0] = 2'b01;
        step(1);
        chk("t4_ge2", 16'(led[0]), 16'h1);
        mode[1:0] = 2'b10;
        step(1);
        chk("t4_le2", 16'(led[0]), 16'h0);
        mode[1:0] = 2'b11;
        step(1);
        chk("t4_odd", 16'(led[0]), 16'h1);
        target[2:0] = 3'd7;
        mode[1:0]   = 2'b01;
        step(1);
        chk("t4_ge7", 16'(led[0]), 16'h0);
        mode[1:0] = 2'b10;
        step(1);
        chk("t4_le7", 16'(led[0]), 16'h1);
        chk("t4_ch1", 16'(led[1]), 16'h1);

        // Reset mid-debounce
        mode[1:0]   = 2'b00;
        target[2:0] = 3'd2;
        step(1);
        chk("t5_pre", 16'(led), 16'h2);
        sw = 8'b0001_0011;
        step(2);
        reset = 1'b1;
        #1;
        chk("t5_in_reset", 16'(led), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(7);
        chk("t5_edge7", 16'(led), 16'h0);
        step(1);
        chk("t5_edge8", 16'(led), 16'h3);

`ifdef MATCH_COUNT_EN
        reset = 1'b1;
        step(1);
        chk("t6_cnt_rst", match_cnt, 16'h0);
        reset = 1'b0;
        step(8);
        chk("t6_led", 16'(led), 16'h3);
        chk("t6_cnt_first", match_cnt, 16'h0101);
        for (int i = 0; i < 300; i++) begin
            sw[3:0] = 4'b0111;
            step(9);
            sw[3:0] = 4'b0011;
            step(9);
            if (i == 9) chk("t6_cnt_mid", match_cnt, 16'h010B);
        end
        chk("t6_cnt_ch0_sat", 16'(match_cnt[7:0]), 16'h00FF);
        chk("t6_cnt_ch1", 16'(match_cnt[15:8]), 16'h0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
